rob_commit_unit: RTL

Reorder buffer for the out-of-order core. Allocates an ROB position per issued instruction and supplies the tags that the reservation station and LSB wait on. Absorbs ALU/LSB result broadcasts, answers operand-readiness lookups from issue, and retires in order. Commits register writes and store releases, and raises rollback plus a redirect PC on a mispredicted branch.

---
 rtl/rob_commit_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: reorder buffer with tag allocation, result capture, operand lookup and in-order retire.
// Mispredicted branches flush the whole buffer at their retire edge and pulse rollback for one cycle.
module rob_commit_unit #(
    parameter int ROB_SIZE = 16,
    parameter int POS_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue,
    input  logic [4:0]       issue_rd,
    input  logic             issue_is_branch,
    input  logic             issue_is_store,
    input  logic             issue_pred_jump,
    input  logic [31:0]      issue_pc,
    output logic [POS_W-1:0] issue_rob_pos,
    output logic             rob_nxt_full,
    input  logic [POS_W-1:0] rs1_pos,
    output logic             rs1_ready,
    output logic [31:0]      rs1_val,
    input  logic [POS_W-1:0] rs2_pos,
    output logic             rs2_ready,
    output logic [31:0]      rs2_val,
    input  logic             alu_result,
    input  logic [POS_W-1:0] alu_result_rob_pos,
    input  logic [31:0]      alu_result_val,
    input  logic             alu_result_jump,
    input  logic [31:0]      alu_result_pc,
    input  logic             lsb_result,
    input  logic [POS_W-1:0] lsb_result_rob_pos,
    input  logic [31:0]      lsb_result_val,
    output logic             commit_reg,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic [POS_W-1:0] commit_rob_pos,
    output logic             commit_store,
    output logic             rollback,
    output logic [31:0]      rollback_pc
);
    logic [POS_W-1:0]    head, tail;
    logic [POS_W:0]      count;
    logic [ROB_SIZE-1:0] busy, ready, is_branch, is_store, pred_jump, real_jump;
    logic [4:0]          rd     [ROB_SIZE];
    logic [31:0]         val    [ROB_SIZE];
    logic [31:0]         pc     [ROB_SIZE];
    logic [31:0]         target [ROB_SIZE];
    logic                live, retire, mispredict, issue_ok, alu_ok, lsb_ok;
    logic                alu_hit1, lsb_hit1, alu_hit2, lsb_hit2;
    logic [POS_W+1:0]    nxt_count;

    always_comb begin
        live          = rdy && !rollback;
        retire        = rdy && busy[head] && ready[head];
        mispredict    = retire && is_branch[head] && (real_jump[head] != pred_jump[head]);
        issue_ok      = live && issue;
        alu_ok        = live && alu_result && busy[alu_result_rob_pos];
        lsb_ok        = live && lsb_result && busy[lsb_result_rob_pos];
        nxt_count     = {1'b0, count} + (POS_W+2)'(issue) - (POS_W+2)'(retire);
        rob_nxt_full  = nxt_count == (POS_W+2)'(ROB_SIZE);
        issue_rob_pos = tail;
        // same-cycle broadcasts bypass the entry storage
        alu_hit1      = alu_result && alu_result_rob_pos == rs1_pos;
        lsb_hit1      = lsb_result && lsb_result_rob_pos == rs1_pos;
        alu_hit2      = alu_result && alu_result_rob_pos == rs2_pos;
        lsb_hit2      = lsb_result && lsb_result_rob_pos == rs2_pos;
        rs1_ready     = !rollback && (ready[rs1_pos] || alu_hit1 || lsb_hit1);
        rs2_ready     = !rollback && (ready[rs2_pos] || alu_hit2 || lsb_hit2);
        rs1_val       = alu_hit1 ? alu_result_val : lsb_hit1 ? lsb_result_val : val[rs1_pos];
        rs2_val       = alu_hit2 ? alu_result_val : lsb_hit2 ? lsb_result_val : val[rs2_pos];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            busy           <= '0;
            ready          <= '0;
            commit_reg     <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_rob_pos <= '0;
            commit_store   <= 1'b0;
            rollback       <= 1'b0;
            rollback_pc    <= '0;
        end else begin
            commit_reg   <= 1'b0;
            commit_store <= 1'b0;
            rollback     <= 1'b0;
            if (alu_ok) ready[alu_result_rob_pos] <= 1'b1;
            if (lsb_ok) ready[lsb_result_rob_pos] <= 1'b1;
            if (retire) begin
                busy[head]     <= 1'b0;
                head           <= head + 1'b1;
                commit_rob_pos <= head;
                commit_rd      <= rd[head];
                commit_val     <= val[head];
                commit_reg     <= !is_branch[head] && !is_store[head] && rd[head] != 5'd0;
                commit_store   <= !is_branch[head] && is_store[head];
            end
            if (issue_ok) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= issue_is_store;
                tail        <= tail + 1'b1;
            end
            if (rdy) count <= count + (POS_W+1)'(issue_ok) - (POS_W+1)'(retire);
            // a wrong-path branch discards everything younger, including this cycle's issue
            if (mispredict) begin
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                busy        <= '0;
                rollback    <= 1'b1;
                rollback_pc <= real_jump[head] ? target[head] : pc[head] + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alu_ok) begin
            val[alu_result_rob_pos]       <= alu_result_val;
            real_jump[alu_result_rob_pos] <= alu_result_jump;
            target[alu_result_rob_pos]    <= alu_result_pc;
        end
        if (lsb_ok) val[lsb_result_rob_pos] <= lsb_result_val;
        if (issue_ok) begin
            rd[tail]        <= issue_rd;
            is_branch[tail] <= issue_is_branch;
            is_store[tail]  <= issue_is_store;
            pred_jump[tail] <= issue_pred_jump;
            pc[tail]        <= issue_pc;
        end
    end

    issue_not_full: assert property (@(posedge clk) disable iff (rst)
        !(rdy && issue && !rollback && count == (POS_W+1)'(ROB_SIZE)));
endmodule
